// File: rtl/grn_node_param_if.sv
// ---------------------------------------------------------------------------
// grn_node_param_if
// Bundle of every non-clock signal of one parametrised gene node.
//   master : network fabric side, drives strobes, regulators and config,
//            observes state / upd / flip_cnt.
//   slave  : the node itself.
// Signals:
//   reset_nos   network re-initialise strobe
//   init_state  per-lane value loaded on reset_nos
//   start       per-lane update strobe
//   reg_in      regulator values, lane-major (lane L at [L*N_IN +: N_IN])
//   cfg_wr      latch all cfg_* inputs
//   cfg_mode    00 OR, 01 AND, 10 threshold, 11 hold
//   cfg_inhib   per-regulator inversion mask
//   cfg_thresh  threshold used in mode 10
//   cfg_div     per-lane update-rate divider, lane-major
//   state       registered node state, one bit per lane
//   upd         one-cycle pulse per lane that performed an update
//   flip_cnt    per-lane saturating count of state-changing updates
// ---------------------------------------------------------------------------
interface grn_node_param_if #(
    parameter int N_IN    = 4,
    parameter int N_LANES = 2,
    parameter int DIV_W   = 2,
    parameter int CNT_W   = 16
);
    localparam int TH_W = $clog2(N_IN + 1);

    logic                       reset_nos;
    logic [N_LANES-1:0]         init_state;
    logic [N_LANES-1:0]         start;
    logic [N_LANES*N_IN-1:0]    reg_in;
    logic                       cfg_wr;
    logic [1:0]                 cfg_mode;
    logic [N_IN-1:0]            cfg_inhib;
    logic [TH_W-1:0]            cfg_thresh;
    logic [N_LANES*DIV_W-1:0]   cfg_div;
    logic [N_LANES-1:0]         state;
    logic [N_LANES-1:0]         upd;
    logic [N_LANES*CNT_W-1:0]   flip_cnt;

    modport master (
        output reset_nos, init_state, start, reg_in,
        output cfg_wr, cfg_mode, cfg_inhib, cfg_thresh, cfg_div,
        input  state, upd, flip_cnt
    );

    modport slave (
        input  reset_nos, init_state, start, reg_in,
        input  cfg_wr, cfg_mode, cfg_inhib, cfg_thresh, cfg_div,
        output state, upd, flip_cnt
    );
endinterface

// File: rtl/grn_node_param.sv
// ---------------------------------------------------------------------------
// grn_node_param
// Parametrised Boolean gene node. Each of N_LANES independent lanes holds one
// state bit which, on a divided start strobe, is replaced by f(reg_in) where
// f is OR / AND / threshold / hold over the inhibitor-adjusted regulators.
// Ports:
//   clk  single clock
//   rst  synchronous active-high reset (highest priority)
//   bus  grn_node_param_if slave modport (strobes, regulators, config,
//        registered outputs state / upd / flip_cnt)
// ---------------------------------------------------------------------------
module grn_node_param #(
    parameter int N_IN    = 4,
    parameter int N_LANES = 2,
    parameter int DIV_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    grn_node_param_if.slave      bus
);
    localparam int TH_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Shared configuration registers
    logic [1:0]               mode_q,   mode_d;
    logic [N_IN-1:0]          inhib_q,  inhib_d;
    logic [TH_W-1:0]          thresh_q, thresh_d;
    logic [N_LANES*DIV_W-1:0] div_q,    div_d;

    // Per-lane state
    logic [N_LANES-1:0]       state_q,  state_d;
    logic [N_LANES-1:0]       upd_q,    upd_d;
    logic [N_LANES*DIV_W-1:0] ph_q,     ph_d;
    logic [N_LANES*CNT_W-1:0] cnt_q,    cnt_d;

    // Combinational next-state value per lane
    logic [N_LANES-1:0]                 f_val;
    logic [N_LANES-1:0][N_IN-1:0]       e_lane;
    logic [N_LANES-1:0][TH_W-1:0]       pop_lane;

    // Evaluate the combining function for every lane from the current config.
    // The popcount never exceeds N_IN, so it fits TH_W; a threshold of 0 is
    // then always met and a threshold above N_IN never is, with no special
    // casing needed.
    always_comb begin
        f_val    = '0;
        e_lane   = '0;
        pop_lane = '0;
        for (int l = 0; l < N_LANES; l++) begin
            e_lane[l] = bus.reg_in[l*N_IN +: N_IN] ^ inhib_q;
            for (int i = 0; i < N_IN; i++) begin
                pop_lane[l] = pop_lane[l] + TH_W'(e_lane[l][i]);
            end
            case (mode_q)
                2'b00:   f_val[l] = |e_lane[l];
                2'b01:   f_val[l] = &e_lane[l];
                2'b10:   f_val[l] = (pop_lane[l] >= thresh_q);
                default: f_val[l] = state_q[l];
            endcase
        end
    end

    // Next-state logic for config, lane state, phase counters and flip
    // counters. The function above reads the old config registers, so a
    // cfg_wr coinciding with a strobe still updates with the old settings.
    // reset_nos overrides every strobe in its cycle but leaves config alone.
    always_comb begin
        mode_d   = mode_q;
        inhib_d  = inhib_q;
        thresh_d = thresh_q;
        div_d    = div_q;
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        upd_d    = '0;

        if (bus.cfg_wr) begin
            mode_d   = bus.cfg_mode;
            inhib_d  = bus.cfg_inhib;
            thresh_d = bus.cfg_thresh;
            div_d    = bus.cfg_div;
        end

        if (bus.reset_nos) begin
            state_d = bus.init_state;
            ph_d    = '0;
            cnt_d   = '0;
        end else begin
            for (int l = 0; l < N_LANES; l++) begin
                if (bus.start[l]) begin
                    if (ph_q[l*DIV_W +: DIV_W] == '0) begin
                        upd_d[l]   = 1'b1;
                        state_d[l] = f_val[l];
                        if ((f_val[l] != state_q[l]) &&
                            (cnt_q[l*CNT_W +: CNT_W] != CNT_MAX)) begin
                            cnt_d[l*CNT_W +: CNT_W] = cnt_q[l*CNT_W +: CNT_W] + CNT_W'(1);
                        end
                    end
                    // Using >= rather than == lets a lowered divider pull an
                    // out-of-range phase back to 0 on the next strobe.
                    if (ph_q[l*DIV_W +: DIV_W] >= div_q[l*DIV_W +: DIV_W]) begin
                        ph_d[l*DIV_W +: DIV_W] = '0;
                    end else begin
                        ph_d[l*DIV_W +: DIV_W] = ph_q[l*DIV_W +: DIV_W] + DIV_W'(1);
                    end
                end
            end
        end
    end

    // Register bank. Reset config is a plain OR node updating every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 2'b00;
            inhib_q  <= '0;
            thresh_q <= TH_W'(1);
            div_q    <= '0;
            state_q  <= '0;
            upd_q    <= '0;
            ph_q     <= '0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            inhib_q  <= inhib_d;
            thresh_q <= thresh_d;
            div_q    <= div_d;
            state_q  <= state_d;
            upd_q    <= upd_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.upd      = upd_q;
    assign bus.flip_cnt = cnt_q;
endmodule

// File: tb/tb_grn_node_param.sv
// ---------------------------------------------------------------------------
// tb_grn_node_param
// Directed bench for grn_node_param with N_IN=4, N_LANES=2, DIV_W=2 and a
// narrow CNT_W=3 flip counter so saturation is reachable quickly.
// Expected values are hand-derived from the node's behaviour.
// ---------------------------------------------------------------------------
module tb_grn_node_param;
    localparam int N_IN    = 4;
    localparam int N_LANES = 2;
    localparam int DIV_W   = 2;
    localparam int CNT_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks_total  = 0;
    int checks_passed = 0;

    grn_node_param_if #(.N_IN(N_IN), .N_LANES(N_LANES), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    grn_node_param #(.N_IN(N_IN), .N_LANES(N_LANES), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // One-cycle start strobe with the given regulator pattern
    task automatic applyStimulus(input logic [N_LANES-1:0] strobe, input logic [N_LANES*N_IN-1:0] regs);
        bus.start  = strobe;
        bus.reg_in = regs;
        tick();
        bus.start  = '0;
    endtask

    // One-cycle config write with no strobe
    task automatic writeConfig(input logic [1:0] mode, input logic [N_IN-1:0] inhib,
                               input logic [2:0] thresh, input logic [N_LANES*DIV_W-1:0] div);
        bus.cfg_mode   = mode;
        bus.cfg_inhib  = inhib;
        bus.cfg_thresh = thresh;
        bus.cfg_div    = div;
        bus.cfg_wr     = 1'b1;
        tick();
        bus.cfg_wr     = 1'b0;
    endtask

    // One-cycle network re-initialise
    task automatic reinit(input logic [N_LANES-1:0] init);
        bus.init_state = init;
        bus.reset_nos  = 1'b1;
        tick();
        bus.reset_nos  = 1'b0;
    endtask

    initial begin
        bus.reset_nos  = 1'b1;
        bus.init_state = 2'b11;
        bus.start      = 2'b11;
        bus.reg_in     = 8'hFF;
        bus.cfg_wr     = 1'b0;
        bus.cfg_mode   = 2'b00;
        bus.cfg_inhib  = '0;
        bus.cfg_thresh = 3'd1;
        bus.cfg_div    = '0;

        // rst wins over reset_nos and start arriving together
        tick();
        tick();
        checkOutput("rst_state", 32'(bus.state), 32'h0);
        checkOutput("rst_upd",   32'(bus.upd),   32'h0);
        checkOutput("rst_cnt",   32'(bus.flip_cnt), 32'h0);

        bus.reset_nos = 1'b0;
        bus.start     = '0;
        bus.reg_in    = '0;
        rst = 1'b0;
        tick();

        // Reset defaults behave as a plain OR node
        reinit(2'b00);
        checkOutput("nos_state", 32'(bus.state), 32'h0);
        applyStimulus(2'b11, 8'b0000_0100);
        checkOutput("def_state", 32'(bus.state), 32'h1);
        checkOutput("def_upd",   32'(bus.upd),   32'h3);
        checkOutput("def_cnt",   32'(bus.flip_cnt), 32'h1);
        tick();
        checkOutput("upd_pulse", 32'(bus.upd), 32'h0);

        // Divider: lane0 div=1, lane1 div=0, start held for four cycles
        writeConfig(2'b00, 4'b0000, 3'd1, 4'b00_01);
        reinit(2'b00);
        bus.start  = 2'b11;
        bus.reg_in = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("div_upd%0d", k), 32'(bus.upd), (k % 2 == 0) ? 32'h3 : 32'h2);
        end
        bus.start = '0;

        // Mode sweep on lane0 with reg_in=0111, inhib=0001 -> e=0110
        writeConfig(2'b00, 4'b0001, 3'd1, 4'b00_00);
        reinit(2'b00);
        applyStimulus(2'b01, 8'b0000_0111);
        checkOutput("or_state", 32'(bus.state), 32'h1);
        checkOutput("or_cnt",   32'(bus.flip_cnt), 32'h1);
        writeConfig(2'b01, 4'b0001, 3'd1, 4'b00_00);
        applyStimulus(2'b01, 8'b0000_0111);
        checkOutput("and_state", 32'(bus.state), 32'h0);
        checkOutput("and_cnt",   32'(bus.flip_cnt), 32'h2);
        writeConfig(2'b10, 4'b0001, 3'd3, 4'b00_00);
        applyStimulus(2'b01, 8'b0000_0111);
        checkOutput("th3_state", 32'(bus.state), 32'h0);
        checkOutput("th3_upd",   32'(bus.upd),   32'h1);
        checkOutput("th3_cnt",   32'(bus.flip_cnt), 32'h2);
        writeConfig(2'b10, 4'b0001, 3'd2, 4'b00_00);
        applyStimulus(2'b01, 8'b0000_0111);
        checkOutput("th2_state", 32'(bus.state), 32'h1);
        checkOutput("th2_cnt",   32'(bus.flip_cnt), 32'h3);
        writeConfig(2'b11, 4'b0001, 3'd2, 4'b00_00);
        applyStimulus(2'b01, 8'b0000_0000);
        checkOutput("hold_state", 32'(bus.state), 32'h1);
        checkOutput("hold_cnt",   32'(bus.flip_cnt), 32'h3);

        // Threshold extremes: above N_IN never met, zero always met
        writeConfig(2'b10, 4'b0000, 3'd7, 4'b00_00);
        applyStimulus(2'b01, 8'b0000_1111);
        checkOutput("th7_state", 32'(bus.state), 32'h0);
        writeConfig(2'b10, 4'b0000, 3'd0, 4'b00_00);
        applyStimulus(2'b01, 8'b0000_0000);
        checkOutput("th0_state", 32'(bus.state), 32'h1);

        // reset_nos drops a coincident strobe and clears a nonzero phase
        writeConfig(2'b00, 4'b0000, 3'd1, 4'b00_01);
        applyStimulus(2'b01, 8'h00);
        bus.init_state = 2'b10;
        bus.reset_nos  = 1'b1;
        bus.start      = 2'b11;
        bus.reg_in     = 8'hFF;
        tick();
        bus.reset_nos  = 1'b0;
        bus.start      = '0;
        checkOutput("nos_pri_state", 32'(bus.state), 32'h2);
        checkOutput("nos_pri_upd",   32'(bus.upd),   32'h0);
        checkOutput("nos_pri_cnt",   32'(bus.flip_cnt), 32'h0);
        applyStimulus(2'b01, 8'h01);
        checkOutput("nos_next_upd",   32'(bus.upd),   32'h1);
        checkOutput("nos_next_state", 32'(bus.state), 32'h3);
        checkOutput("nos_next_cnt",   32'(bus.flip_cnt), 32'h1);

        // cfg_wr together with start: update uses the old OR config
        writeConfig(2'b00, 4'b0000, 3'd1, 4'b00_00);
        reinit(2'b00);
        bus.cfg_mode   = 2'b01;
        bus.cfg_inhib  = 4'b0000;
        bus.cfg_thresh = 3'd1;
        bus.cfg_div    = 4'b00_00;
        bus.cfg_wr     = 1'b1;
        bus.start      = 2'b01;
        bus.reg_in     = 8'h01;
        tick();
        bus.cfg_wr     = 1'b0;
        bus.start      = '0;
        checkOutput("cfgwr_old_state", 32'(bus.state), 32'h1);
        checkOutput("cfgwr_old_upd",   32'(bus.upd),   32'h1);
        applyStimulus(2'b01, 8'h01);
        checkOutput("cfgwr_new_state", 32'(bus.state), 32'h0);

        // Saturation: ten back-to-back flips on lane0, counter stops at 7
        writeConfig(2'b00, 4'b0000, 3'd1, 4'b00_00);
        reinit(2'b00);
        bus.start = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            bus.reg_in = (k % 2 == 1) ? 8'h01 : 8'h00;
            tick();
            checkOutput($sformatf("sat_cnt%0d", k), 32'(bus.flip_cnt[CNT_W-1:0]), (k > 7) ? 32'd7 : 32'(k));
        end
        bus.start = '0;
        checkOutput("sat_lane1_cnt", 32'(bus.flip_cnt[2*CNT_W-1:CNT_W]), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
